cnn_conv_sequencer: RTL and testbench
=====================================

# cnn_conv_sequencer

Control sequencer that time-multiplexes one shared multiply-accumulate (MAC) engine across every filter, output position and filter tap of the convolution layer. For each filter and output pixel it generates the image-buffer read address and the weight address for each tap. It then issues clear/accumulate strobes to the MAC and a write strobe with the destination address into the convolution output buffer, which feeds the pooling stage. It sits between the top-level `cnn` control `always` block (start/done) and the conv datapath memories.

## Interface
- `INPUT_SIZE`, 28, square input image edge length in pixels.
- `FILTER_SIZE`, 3, square filter edge length; taps per window = `FILTER_SIZE*FILTER_SIZE`.
- `NUM_FILTERS`, 16, number of filters.
- `STRIDE`, 2, convolution stride.
- Derived localparams:
  - `OUT_SIZE = (INPUT_SIZE-FILTER_SIZE)/STRIDE+1` (13 at defaults).
  - `IMG_AW = $clog2(INPUT_SIZE*INPUT_SIZE)` (10).
  - `W_AW = $clog2(NUM_FILTERS*FILTER_SIZE*FILTER_SIZE)` (8).
  - `OUT_AW = $clog2(NUM_FILTERS*OUT_SIZE*OUT_SIZE)` (12).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rstb`  in  1  reset, asynchronous, active-high (1 = reset asserted).
- `start`  in  1  one-cycle request to begin a full layer pass; ignored unless IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE with no `done`.
- `stall`  in  1  freezes the sequencer while high.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when the layer pass completes.
- `img_rd`  out  1  image-buffer read strobe.
- `img_addr`  out  IMG_AW  image-buffer read address.
- `wgt_addr`  out  W_AW  weight read address, issued with `img_addr`.
- `mac_clr`  out  1  load the MAC with the product instead of accumulating; first tap of a window.
- `mac_en`  out  1  MAC operate enable.
- `out_we`  out  1  conv output buffer write strobe.
- `out_addr`  out  OUT_AW  conv output buffer write address.
- `filter_idx`  out  $clog2(NUM_FILTERS)  filter currently being issued.

## Operation
**Counters:** `f` (filter), `r` (output row), `c` (output column), `t` (tap, split into `ty = t / FILTER_SIZE` and `tx = t % FILTER_SIZE`). The nesting is `f` outermost, then `r`, then `c`, with `t` innermost. Each counter wraps to 0 at its limit and carries into the next outer counter.

**Issue stage (cycle n, RUN state, `stall` low):**
- `img_rd = 1`.
- `img_addr = (r*STRIDE+ty)*INPUT_SIZE + c*STRIDE + tx`.
- `wgt_addr = f*FILTER_SIZE*FILTER_SIZE + t`.

**MAC stage (cycle n+1):** `mac_en = 1`. `mac_clr = 1` when the issued tap was `t == 0`.

**Write stage (cycle n+2):** for the last tap (`t == FILTER_SIZE*FILTER_SIZE-1`) only:
- `out_we = 1`.
- `out_addr = f*OUT_SIZE*OUT_SIZE + r*OUT_SIZE + c`, taken from a pipelined copy of `f`, `r`, `c`.

**Address arithmetic:** computed at full width, then truncated to the port width. The address limits above guarantee nothing is lost to truncation.

**FSM:**
- IDLE:
  - `start` → RUN, with all counters cleared to 0.
- RUN:
  - Issue one tap per unstalled cycle.
  - After issuing the final tap (`f`, `r`, `c` and `t` all at maximum) → DRAIN.
- DRAIN:
  - Two unstalled cycles, which flush the MAC and write stages.
  - Then → DONE.
- DONE:
  - `done = 1` for one cycle, then → IDLE.
- `abort` from any state → IDLE next cycle:
  - Pipeline valid bits clear.
  - No `out_we` or `done` is generated after the abort cycle.

**Stall:**
- While `stall` is high, every internal register (counters, FSM, pipeline valids) holds its value.
- `img_rd`, `mac_en`, `out_we` and `done` are forced to 0 during stall cycles.
- Address outputs hold their values.
- The image/weight memories are responsible for holding their read data across the stall.

**Simultaneous events:**
- `abort` overrides `stall` and `start`.
- `start` while busy is ignored.
- `start` in the DONE cycle is ignored.

## Timing
**Reset values:** while `rstb` is asserted, all outputs are 0, the FSM is IDLE and all counters are 0. Assertion takes effect immediately, including mid-pass; there is no `done` after a reset.

**Start:** `start` sampled at edge k gives `busy = 1` and the first issue (`img_rd = 1`, `img_addr = 0`, `wgt_addr = 0`) from cycle k+1.

**Latency:**
- Issue to `mac_en`: 1 cycle.
- Issue of the last tap to `out_we`: 2 cycles.

**Full-pass length with no stalls:** `NUM_FILTERS*OUT_SIZE*OUT_SIZE*FILTER_SIZE*FILTER_SIZE` issue cycles (24336 at defaults), plus 2 DRAIN cycles, plus 1 DONE cycle. `busy` is high for exactly 24338 cycles.

**Write count:** `out_we` pulses exactly `NUM_FILTERS*OUT_SIZE*OUT_SIZE` times (2704) per pass, one every 9 unstalled cycles.

## Test plan
- **Reset and start:** reset, then pulse `start`. Require:
  - First window issues `img_addr` 0, 1, 2, 28, 29, 30, 56, 57, 58 with `wgt_addr` 0..8.
  - `mac_clr` only with the first `mac_en`.
  - `out_we` with `out_addr = 0` two cycles after the last tap.
- **Window stepping:** at the second window (`r = 0`, `c = 1`), require the first `img_addr = 2`. At `f = 1`, require the first `wgt_addr = 9`.
- **Full pass:** run a complete pass. Require:
  - Final window `img_addr` ends at 754 (`r = 12`, `c = 12`, tap 8).
  - Last `out_addr = 2703`.
  - 2704 `out_we` pulses.
  - `done` pulses exactly 24338 cycles after `busy` rises.
  - `busy` falls the cycle after `done`.
- **Stall:** assert `stall` for 5 cycles mid-window (tap 4). Require:
  - Strobes are 0 and addresses are held.
  - Issue resumes at tap 5.
  - Total pass length grows by exactly 5 cycles.
- **Abort and restart:** assert `abort` at `f = 3`. Require:
  - IDLE next cycle, `busy = 0`, no `done`, no further `out_we`.
  - A subsequent `start` restarts from address 0.
- **Reset mid-pass and start while busy:** assert `rstb` mid-pass. Require all outputs 0 immediately. Separately, pulse `start` while busy and require the sequence to be unaffected.

Source files
------------

// File: rtl/cnn_conv_sequencer.sv
// rtl/cnn_conv_sequencer.sv - conv-layer sequencer sharing one MAC across filters, pixels and taps
//
// Ports:
//   clk, rstb          clock, async active-high reset
//   start, abort       begin a layer pass (IDLE only) / cancel to IDLE
//   stall              freeze all state; strobes forced low, addresses held
//   busy, done         RUN/DRAIN indicator, one-cycle completion pulse
//   img_rd, img_addr   image-buffer read strobe and address (issue stage)
//   wgt_addr           weight address, issued with img_addr
//   mac_clr, mac_en    MAC load/accumulate strobes (one cycle after issue)
//   out_we, out_addr   conv output buffer write (two cycles after last tap)
//   filter_idx         filter currently being issued
module cnn_conv_sequencer #(
  parameter int INPUT_SIZE  = 28,
  parameter int FILTER_SIZE = 3,
  parameter int NUM_FILTERS = 16,
  parameter int STRIDE      = 2,
  localparam int OUT_SIZE   = (INPUT_SIZE - FILTER_SIZE) / STRIDE + 1,
  localparam int TAPS       = FILTER_SIZE * FILTER_SIZE,
  localparam int IMG_AW     = $clog2(INPUT_SIZE * INPUT_SIZE),
  localparam int W_AW       = $clog2(NUM_FILTERS * TAPS),
  localparam int OUT_AW     = $clog2(NUM_FILTERS * OUT_SIZE * OUT_SIZE),
  localparam int FW         = $clog2(NUM_FILTERS)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              img_rd,
  output logic [IMG_AW-1:0] img_addr,
  output logic [W_AW-1:0]   wgt_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_addr,
  output logic [FW-1:0]     filter_idx
);

  localparam int PW = $clog2(OUT_SIZE);
  localparam int TW = $clog2(TAPS);

  localparam logic [FW-1:0] F_MAX = FW'(NUM_FILTERS - 1);
  localparam logic [PW-1:0] P_MAX = PW'(OUT_SIZE - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic          drain_cnt;

  // Issue-stage counters: these are the live filter/row/col/tap being issued.
  logic [FW-1:0] f;
  logic [PW-1:0] r, c;
  logic [TW-1:0] t;

  // MAC stage: valid, first-tap, last-tap, and a copy of f/r/c for the write address.
  logic          v1, clr1, last1;
  logic [FW-1:0] f1;
  logic [PW-1:0] r1, c1;

  // Write stage.
  logic          v2;
  logic [OUT_AW-1:0] out_addr_q;

  logic [31:0] ty, tx;

  always_comb begin
    ty = 32'(t) / FILTER_SIZE;
    tx = 32'(t) % FILTER_SIZE;
  end

  // Full-width arithmetic; parameter limits guarantee the truncation is lossless.
  assign img_addr = IMG_AW'((32'(r) * STRIDE + ty) * INPUT_SIZE + 32'(c) * STRIDE + tx);
  assign wgt_addr = W_AW'(32'(f) * TAPS + 32'(t));

  // Strobes are gated by stall in the same cycle; everything else comes from registers.
  assign busy       = (state == RUN) || (state == DRAIN);
  assign img_rd     = (state == RUN) && !stall;
  assign done       = (state == DONE) && !stall;
  assign mac_en     = v1 && !stall;
  assign mac_clr    = v1 && clr1 && !stall;
  assign out_we     = v2 && !stall;
  assign out_addr   = out_addr_q;
  assign filter_idx = f;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state      <= IDLE;
      drain_cnt  <= 1'b0;
      f          <= '0;
      r          <= '0;
      c          <= '0;
      t          <= '0;
      v1         <= 1'b0;
      clr1       <= 1'b0;
      last1      <= 1'b0;
      f1         <= '0;
      r1         <= '0;
      c1         <= '0;
      v2         <= 1'b0;
      out_addr_q <= '0;
    end else if (abort) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      f         <= '0;
      r         <= '0;
      c         <= '0;
      t         <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
    end else if (!stall) begin
      v1    <= (state == RUN);
      clr1  <= (t == '0);
      last1 <= (t == T_MAX);
      f1    <= f;
      r1    <= r;
      c1    <= c;
      v2    <= v1 && last1;
      if (v1 && last1) begin
        out_addr_q <= OUT_AW'(32'(f1) * OUT_SIZE * OUT_SIZE + 32'(r1) * OUT_SIZE + 32'(c1));
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            f     <= '0;
            r     <= '0;
            c     <= '0;
            t     <= '0;
          end
        end
        RUN: begin
          // Nested wrap: t innermost, then c, r, f; all wrap to 0 after the final tap.
          if (t == T_MAX) begin
            t <= '0;
            if (c == P_MAX) begin
              c <= '0;
              if (r == P_MAX) begin
                r <= '0;
                if (f == F_MAX) begin
                  f         <= '0;
                  state     <= DRAIN;
                  drain_cnt <= 1'b0;
                end else begin
                  f <= f + 1'b1;
                end
              end else begin
                r <= r + 1'b1;
              end
            end else begin
              c <= c + 1'b1;
            end
          end else begin
            t <= t + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
// tb/tb_cnn_conv_sequencer.sv - directed self-checking bench for cnn_conv_sequencer
module tb_cnn_conv_sequencer;

  localparam int IMG_AW = 10;
  localparam int W_AW   = 8;
  localparam int OUT_AW = 12;
  localparam int FW     = 4;

  logic              clk = 1'b0;
  logic              rstb, start, abort, stall;
  logic              busy, done, img_rd, mac_clr, mac_en, out_we;
  logic [IMG_AW-1:0] img_addr;
  logic [W_AW-1:0]   wgt_addr;
  logic [OUT_AW-1:0] out_addr;
  logic [FW-1:0]     filter_idx;

  always #5 clk = ~clk;

  cnn_conv_sequencer dut (
    .clk        (clk),
    .rstb       (rstb),
    .start      (start),
    .abort      (abort),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .img_rd     (img_rd),
    .img_addr   (img_addr),
    .wgt_addr   (wgt_addr),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .out_we     (out_we),
    .out_addr   (out_addr),
    .filter_idx (filter_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  int win0 [9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};

  int busy_n, we_n, clr_n, clr_bad, done_at, last_out, last_img;
  int first_we_cyc, first_we_addr, img9, f1_cyc, f1_wgt, f1_img, clr_first;
  int stall_viol, stall_addr_bad, res_img, res_wgt, idle_bad, n;
  logic prev_busy, busy_at_done, prev_busy_at_done;

  task automatic run_pass(input int stall_at, input int restart_at, input bit first);
    busy_n = 0; we_n = 0; clr_n = 0; clr_bad = 0; done_at = -1; last_out = -1; last_img = -1;
    first_we_cyc = -1; first_we_addr = -1; img9 = -1; f1_cyc = -1; f1_wgt = -1; f1_img = -1;
    clr_first = -1; stall_viol = 0; stall_addr_bad = 0; res_img = -1; res_wgt = -1;
    prev_busy = 1'b0; busy_at_done = 1'b1; prev_busy_at_done = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      stall = (cyc >= stall_at) && (cyc < stall_at + 5);
      start = (cyc == restart_at);
      #1;
      if (busy) busy_n++;
      if (out_we) begin
        we_n++;
        last_out = int'(out_addr);
        if (first_we_cyc < 0) begin
          first_we_cyc  = cyc;
          first_we_addr = int'(out_addr);
        end
      end
      if (mac_clr) begin
        clr_n++;
        if (clr_first < 0) clr_first = cyc;
        if (!mac_en) clr_bad++;
      end
      if (img_rd) last_img = int'(img_addr);
      if (img_rd && filter_idx == 4'd1 && f1_cyc < 0) begin
        f1_cyc = cyc;
        f1_wgt = int'(wgt_addr);
        f1_img = int'(img_addr);
      end
      if (cyc == 9) img9 = int'(img_addr);
      if (first && cyc < 9) begin
        check("win0_rd", 32'(img_rd), 32'd1);
        check("win0_img", 32'(img_addr), 32'(win0[cyc]));
        check("win0_wgt", 32'(wgt_addr), 32'(cyc));
      end
      if (stall) begin
        if (img_rd || mac_en || out_we || done) stall_viol++;
        if (img_addr != 10'd30 || wgt_addr != 8'd5) stall_addr_bad++;
      end
      if (cyc == stall_at + 5) begin
        res_img = int'(img_addr);
        res_wgt = int'(wgt_addr);
      end
      if (done) begin
        done_at           = cyc;
        busy_at_done      = busy;
        prev_busy_at_done = prev_busy;
        break;
      end
      prev_busy = busy;
      @(posedge clk); #1;
    end
    stall = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rstb = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({busy, done, img_rd, img_addr, wgt_addr, mac_clr, mac_en,
                                out_we, out_addr, filter_idx} != '0), 32'd0);
    rstb = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    // Full pass with a start pulse while busy that must be ignored.
    run_pass(100000, 5000, 1'b1);
    check("first_clr_cyc", 32'(clr_first), 32'd1);
    check("clr_count", 32'(clr_n), 32'd2704);
    check("clr_without_en", 32'(clr_bad), 32'd0);
    check("first_we_cyc", 32'(first_we_cyc), 32'd10);
    check("first_we_addr", 32'(first_we_addr), 32'd0);
    check("win1_img", 32'(img9), 32'd2);
    check("f1_cyc", 32'(f1_cyc), 32'd1521);
    check("f1_wgt", 32'(f1_wgt), 32'd9);
    check("f1_img", 32'(f1_img), 32'd0);
    check("last_img", 32'(last_img), 32'd754);
    check("last_out", 32'(last_out), 32'd2703);
    check("we_count", 32'(we_n), 32'd2704);
    check("done_at", 32'(done_at), 32'd24338);
    check("busy_cycles", 32'(busy_n), 32'd24338);
    check("busy_before_done", 32'(prev_busy_at_done), 32'd1);
    check("busy_at_done", 32'(busy_at_done), 32'd0);
    check("idle_after_done", 32'(busy | done), 32'd0);

    // Stall for 5 cycles after tap 4 has issued.
    run_pass(5, -1, 1'b0);
    check("stall_strobes", 32'(stall_viol), 32'd0);
    check("stall_addr_hold", 32'(stall_addr_bad), 32'd0);
    check("resume_img", 32'(res_img), 32'd30);
    check("resume_wgt", 32'(res_wgt), 32'd5);
    check("stall_done_at", 32'(done_at), 32'd24343);
    check("stall_busy_cycles", 32'(busy_n), 32'd24343);
    check("stall_we_count", 32'(we_n), 32'd2704);

    // Abort at the first issue of filter 3.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(img_rd && filter_idx == 4'd3) && n < 10000) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reach", 32'(n), 32'd4563);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    idle_bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy || done || out_we || img_rd || mac_en) idle_bad++;
      @(posedge clk); #1;
    end
    check("abort_quiet", 32'(idle_bad), 32'd0);

    // Restart after abort begins from address 0.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_img0", 32'(img_addr), 32'd0);
    check("restart_wgt0", 32'(wgt_addr), 32'd0);
    check("restart_f0", 32'(filter_idx), 32'd0);
    check("restart_rd", 32'(img_rd), 32'd1);
    @(posedge clk); #1;
    check("restart_img1", 32'(img_addr), 32'd1);

    // Reset mid-pass: outputs clear immediately.
    repeat (100) @(posedge clk);
    #1;
    rstb = 1'b1;
    #1;
    check("midpass_reset", 32'({busy, done, img_rd, img_addr, wgt_addr, mac_clr, mac_en,
                                out_we, out_addr, filter_idx} != '0), 32'd0);
    @(posedge clk); #1;
    rstb = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy || done || out_we) idle_bad++;
    end
    check("post_reset_idle", 32'(idle_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
